// File: rtl/parity_frame_if.sv
// Handshake bundle between link receiver, parity checker and frame consumer.
interface parity_frame_if #(
   parameter int DATA_W    = 8,
   parameter int ERR_CNT_W = 8,
   parameter int BEAT_W    = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    in_data;
   logic                 in_last;
   logic                 in_par;
   logic                 odd_sel;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_par;
   logic                 out_err;
   logic [BEAT_W-1:0]    out_beats;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport slave (
      input  in_valid, in_data, in_last, in_par, odd_sel, out_ready,
      output in_ready, out_valid, out_par, out_err, out_beats, err_cnt
   );

   modport master (
      output in_valid, in_data, in_last, in_par, odd_sel, out_ready,
      input  in_ready, out_valid, out_par, out_err, out_beats, err_cnt
   );
endinterface

// File: rtl/parity_frame_checker.sv
// Streaming parity generator/checker: accumulates parity over multi-beat
// frames, compares against the received parity bit and counts error frames.
module parity_frame_checker #(
   parameter int DATA_W    = 8,
   parameter int ERR_CNT_W = 8,
   parameter int BEAT_W    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   parity_frame_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   state_t              state, state_nxt;
   logic                acc, mode;
   logic [BEAT_W-1:0]   beats;
   logic                accept, first;
   logic                acc_nxt, mode_eff, par_nxt, err_nxt;
   logic [BEAT_W-1:0]   beats_nxt;
   logic                out_par, out_err;
   logic [BEAT_W-1:0]   out_beats;
   logic [ERR_CNT_W-1:0] err_cnt;

   assign bus.in_ready  = (state != REPORT);
   assign bus.out_valid = (state == REPORT);
   assign bus.out_par   = out_par;
   assign bus.out_err   = out_err;
   assign bus.out_beats = out_beats;
   assign bus.err_cnt   = err_cnt;

   assign accept = bus.in_valid & bus.in_ready;
   assign first  = (state == IDLE);

   // Per-beat datapath: the first beat of a frame starts a fresh accumulator
   // and takes the mode straight from odd_sel so a 1-beat frame needs no
   // extra cycle.
   always_comb begin
      acc_nxt  = (first ? 1'b0 : acc) ^ (^bus.in_data);
      mode_eff = first ? bus.odd_sel : mode;
      if (first)
         beats_nxt = BEAT_W'(1);
      else if (&beats)
         beats_nxt = beats;
      else
         beats_nxt = beats + BEAT_W'(1);
      par_nxt = acc_nxt ^ mode_eff;
      err_nxt = bus.in_par ^ par_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bus.in_last ? REPORT : ACCUM;
         ACCUM:   if (accept && bus.in_last) state_nxt = REPORT;
         REPORT:  if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Frame accumulator and mode latch; holds across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= 1'b0;
         mode  <= 1'b0;
         beats <= '0;
      end else if (accept) begin
         acc   <= acc_nxt;
         mode  <= mode_eff;
         beats <= beats_nxt;
      end
   end

   // Result registers load only on REPORT entry, so they hold between frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par   <= 1'b0;
         out_err   <= 1'b0;
         out_beats <= '0;
         err_cnt   <= '0;
      end else if (accept && bus.in_last) begin
         out_par   <= par_nxt;
         out_err   <= err_nxt;
         out_beats <= beats_nxt;
         if (err_nxt && !(&err_cnt))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench: default-width checker plus a 2-bit error counter copy fed
// the same stimulus.
`define CHK(tag, obs, exp) \
   checks++; \
   assert ((obs) === (exp)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
   end

module tb_parity_frame_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   err_model = 0;

   always #5 clk = ~clk;

   parity_frame_if #(.DATA_W(8), .ERR_CNT_W(8), .BEAT_W(8)) ia ();
   parity_frame_if #(.DATA_W(8), .ERR_CNT_W(2), .BEAT_W(8)) ib ();

   parity_frame_checker #(.DATA_W(8), .ERR_CNT_W(8), .BEAT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia.slave));
   parity_frame_checker #(.DATA_W(8), .ERR_CNT_W(2), .BEAT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib.slave));

   assign ib.in_valid  = ia.in_valid;
   assign ib.in_data   = ia.in_data;
   assign ib.in_last   = ia.in_last;
   assign ib.in_par    = ia.in_par;
   assign ib.odd_sel   = ia.odd_sel;
   assign ib.out_ready = ia.out_ready;

   // Offer one beat, wait for acceptance, return 1 ns after the accepting edge.
   task automatic beat(input logic [7:0] d, input logic last, input logic par,
                       input logic odd);
      int n = 0;
      @(negedge clk);
      ia.in_data = d; ia.in_last = last; ia.in_par = par; ia.odd_sel = odd;
      ia.in_valid = 1'b1;
      while (!ia.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         `CHK("beat_accept_timeout", n, 0)
      end
      @(posedge clk);
      #1 ia.in_valid = 1'b0;
   endtask

   // Drain REPORT with random out_ready, bounded.
   task automatic drain();
      int n = 0;
      while (ia.out_valid && n < 20) begin
         @(negedge clk);
         ia.out_ready = (n >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
      end
      `CHK("drain_timeout", ia.out_valid, 1'b0)
   endtask

   initial begin
      logic p, ep;
      int   sat;
      ia.in_valid = 0; ia.in_data = 0; ia.in_last = 0; ia.in_par = 0;
      ia.odd_sel = 0; ia.out_ready = 1;

      // Reset state
      #12;
      `CHK("rst_out_valid", ia.out_valid, 1'b0)
      `CHK("rst_err_cnt", ia.err_cnt, 8'd0)
      `CHK("rst_out_par", ia.out_par, 1'b0)
      `CHK("rst_out_beats", ia.out_beats, 8'd0)
      @(negedge clk) rst_n = 1'b1;
      #1 `CHK("rst_in_ready", ia.in_ready, 1'b1)

      // 1: single beat 0x00 even
      beat(8'h00, 1, 0, 0);
      `CHK("t1_valid", ia.out_valid, 1'b1)
      `CHK("t1_par", ia.out_par, 1'b0)
      `CHK("t1_err", ia.out_err, 1'b0)
      `CHK("t1_beats", ia.out_beats, 8'd1)
      `CHK("t1_in_ready", ia.in_ready, 1'b0)
      @(posedge clk); #1;
      `CHK("t1_valid_drop", ia.out_valid, 1'b0)
      `CHK("t1_par_hold", ia.out_beats, 8'd1)

      // 2: odd mode, 0x01 then 0x03 (odd_sel ignored on 2nd beat)
      beat(8'h01, 0, 0, 1);
      beat(8'h03, 1, 1, 0);
      `CHK("t2_par", ia.out_par, 1'b0)
      `CHK("t2_err", ia.out_err, 1'b1)
      `CHK("t2_err_cnt", ia.err_cnt, 8'd1)
      `CHK("t2_beats", ia.out_beats, 8'd2)
      @(posedge clk); #1;

      // 3: backpressure in REPORT; 0x07 even, in_par=0 -> par 1, err 1
      ia.out_ready = 0;
      beat(8'h07, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ia.in_valid = 1; ia.in_data = 8'hFF; ia.in_last = 1; ia.in_par = 1;
         `CHK("t3_valid", ia.out_valid, 1'b1)
         `CHK("t3_par", ia.out_par, 1'b1)
         `CHK("t3_err", ia.out_err, 1'b1)
         `CHK("t3_in_ready", ia.in_ready, 1'b0)
         `CHK("t3_err_cnt", ia.err_cnt, 8'd2)
         `CHK("t3_beats", ia.out_beats, 8'd1)
      end
      @(negedge clk);
      ia.in_valid = 0; ia.out_ready = 1;
      @(posedge clk); #1;
      `CHK("t3_release", ia.out_valid, 1'b0)
      `CHK("t3_in_ready_back", ia.in_ready, 1'b1)

      // Bubbles mid-frame: 0x01, 3 idle cycles, 0x01 last even -> par 0
      beat(8'h01, 0, 0, 0);
      repeat (3) @(posedge clk);
      beat(8'h01, 1, 0, 1);
      `CHK("bub_par", ia.out_par, 1'b0)
      `CHK("bub_err", ia.out_err, 1'b0)
      `CHK("bub_beats", ia.out_beats, 8'd2)
      @(posedge clk); #1;

      // 5: reset mid-frame, then a clean 0xFF frame
      beat(8'h01, 0, 0, 1);
      beat(8'h02, 0, 0, 0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      `CHK("t5_valid", ia.out_valid, 1'b0)
      `CHK("t5_err_cnt", ia.err_cnt, 8'd0)
      `CHK("t5_par", ia.out_par, 1'b0)
      `CHK("t5_err", ia.out_err, 1'b0)
      `CHK("t5_beats", ia.out_beats, 8'd0)
      @(negedge clk) rst_n = 1'b1;
      beat(8'hFF, 1, 0, 0);
      `CHK("t5_frame_par", ia.out_par, 1'b0)
      `CHK("t5_frame_err", ia.out_err, 1'b0)
      `CHK("t5_frame_beats", ia.out_beats, 8'd1)
      @(posedge clk); #1;

      // 4: five error frames; 2-bit counter saturates at 3
      for (int i = 1; i <= 5; i++) begin
         beat(8'h01, 1, 0, 0);
         `CHK("t4_par", ia.out_par, 1'b1)
         `CHK("t4_cnt_a", ia.err_cnt, 8'(i))
         `CHK("t4_cnt_b", ib.err_cnt, 2'((i > 3) ? 3 : i))
         @(posedge clk); #1;
      end
      err_model = 5;

      // Beat counter saturation: 260 beats of 0x01, even -> par 0, beats 255
      for (int i = 1; i <= 260; i++) beat(8'h01, (i == 260), 0, 0);
      `CHK("sat_beats", ia.out_beats, 8'hFF)
      `CHK("sat_par", ia.out_par, 1'b0)
      `CHK("sat_err", ia.out_err, 1'b0)
      @(posedge clk); #1;

      // 6: sweep all values in both modes, random in_par / out_ready
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < 256; v++) begin
            p  = 1'($urandom_range(0, 1));
            ep = 1'($countones(8'(v)) % 2) ^ 1'(m);
            beat(8'(v), 1, p, 1'(m));
            `CHK("sw_par", ia.out_par, ep)
            `CHK("sw_err", ia.out_err, p ^ ep)
            if (p != ep) err_model++;
            drain();
         end
      end
      sat = (err_model > 255) ? 255 : err_model;
      `CHK("sw_err_cnt_a", ia.err_cnt, 8'(sat))
      `CHK("sw_err_cnt_b", ib.err_cnt, 2'd3)

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
